shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath width; only 32 is required to work.
REQ-002 The block SHALL have parameter NREQ, default 2, meaning number of requesters; legal range 2..4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept; one-hot or zero.
REQ-007 The block SHALL have port req_op, input, NREQ*2 bits: opcode per requester; 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 The block SHALL have port req_data, input, NREQ*N bits: operand per requester.
REQ-009 The block SHALL have port req_shamt, input, NREQ*$clog2(N) bits: shift amount per requester, 0..31.
REQ-010 The block SHALL have port rsp_valid, output, NREQ bits: result valid, one-hot or zero, routed to the owning requester.
REQ-011 The block SHALL have port rsp_ready, input, NREQ bits: per-requester result accept.
REQ-012 The block SHALL have port rsp_data, output, N bits: shared result bus.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: high with rsp_valid when the opcode was illegal.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP; only one operation SHALL be outstanding at a time.
REQ-015 In IDLE, req_ready SHALL be asserted combinationally only for the round-robin winner among the asserted req_valid bits; in EXEC and RESP, req_ready SHALL be 0.
REQ-016 Round-robin: the search SHALL start at (last_grant+1) mod NREQ; last_grant SHALL update only on acceptance.
REQ-017 On an accepted handshake, the block SHALL register op, data, shamt and owner index, and SHALL go IDLE->EXEC.
REQ-018 EXEC SHALL compute through the shift core, register rsp_data and rsp_err, and go EXEC->RESP unconditionally.
REQ-019 In RESP, rsp_valid[owner] SHALL be held at 1 and rsp_data/rsp_err held stable until rsp_ready[owner]=1.
REQ-020 When rsp_ready[owner]=1 in RESP, the block SHALL go RESP->IDLE; the result SHALL be consumed on that edge.
REQ-021 rsp_ready bits of non-owners SHALL be ignored.
REQ-022 Latency: rsp_valid SHALL rise 2 clocks after the accept edge; maximum throughput SHALL be one operation per 3 clocks.
REQ-023 SLL and SRL SHALL zero-fill, SRA SHALL sign-fill from bit N-1, and shamt=0 SHALL return the operand unchanged.
REQ-024 A requester that deasserts req_valid before acceptance SHALL NOT be granted.

Reset
REQ-025 Asserting rst SHALL force IDLE, last_grant=NREQ-1 (requester 0 wins first), rsp_valid=0, rsp_data=0, rsp_err=0 and req_ready=0, immediately and asynchronously.
REQ-026 A reset mid-EXEC or mid-RESP SHALL discard the operation, with no response delivered.

Configuration
REQ-027 With SHIFT_ARBITER_ROTATE_EN defined, opcode 11 SHALL rotate left by shamt and rsp_err SHALL be 0.
REQ-028 Without SHIFT_ARBITER_ROTATE_EN, opcode 11 SHALL produce rsp_data=0 and rsp_err=1, with the handshake and latency unchanged.

Structure
REQ-029 Package shift_arbiter_pkg SHALL hold the shift_op_t enum (SLL, SRL, SRA, ROL) and the FSM state_t enum (IDLE, EXEC, RESP).
REQ-030 Sub-module shift_core SHALL be the combinational datapath: inputs op, data, shamt; outputs result, err. It SHALL reuse the team's existing left/right shifter blocks.

Verification
REQ-031 Single request: req0 SLL data=0x0000_0001, shamt=31 -> accepted, rsp_valid[0] 2 clocks later, rsp_data=0x8000_0000, err=0.
REQ-032 Sign fill: SRA data=0x8000_0000, shamt=4 -> rsp_data=0xF800_0000; SRL with the same operands -> 0x0800_0000.
REQ-033 Fairness: req0 and req1 held valid continuously after reset -> grant order 0,1,0,1 over 4 operations.
REQ-034 Backpressure: rsp_ready[0] held low 5 clocks in RESP -> rsp_valid and rsp_data stable for all 5 clocks, req_ready=0 throughout, IDLE 1 clock after rsp_ready rises.
REQ-035 Rotate: op=11, data=0x8000_0001, shamt=1 -> 0x0000_0003, err=0 with the macro; rsp_data=0, err=1 without it.
REQ-036 Reset in EXEC: rst pulsed low -> rsp_valid never asserts; the next request is granted to req0 with normal latency.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift arbiter: shift opcodes and controller states.
// Opcode ROL is only functional when SHIFT_ARBITER_ROTATE_EN is defined.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/shift_arbiter_shift_core.sv
// Combinational shift datapath built from one left and one right shifter.
// SHIFT_ARBITER_ROTATE_EN enables ROL; otherwise ROL reports err with a zero result.
module shift_core
  import shift_arbiter_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  shift_op_t      op,
  input  logic [N-1:0]   data,
  input  logic [SW-1:0]  shamt,
  output logic [N-1:0]   result,
  output logic           err
);

  logic [N-1:0] shl;
  logic [N-1:0] shr;
  logic         fill;

  // Arithmetic right shift done on the logical shifter by inverting around it.
  assign fill = (op == SRA) ? data[N-1] : 1'b0;
  assign shl  = data << shamt;
  assign shr  = fill ? ~((~data) >> shamt) : (data >> shamt);

`ifdef SHIFT_ARBITER_ROTATE_EN
  localparam logic [SW:0] NW = SW'(0) + (SW+1)'(N);
  logic [SW:0] rot_amt;
  assign rot_amt = NW - {1'b0, shamt};
`endif

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      SLL:     result = shl;
      SRL,
      SRA:     result = shr;
      ROL: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        result = shl | (data >> rot_amt);
`else
        err    = 1'b1;
`endif
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of a shared shifter; one operation outstanding at a time.
// Build option SHIFT_ARBITER_ROTATE_EN enables the rotate-left opcode.
//
// state | meaning
// IDLE  | grant the round-robin winner, capture its operands
// EXEC  | run the shift core, register result and error
// RESP  | hold rsp_valid[owner] until the owner accepts
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*2-1:0]          req_op,
  input  logic [NREQ*N-1:0]          req_data,
  input  logic [NREQ*$clog2(N)-1:0]  req_shamt,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [N-1:0]               rsp_data,
  output logic                       rsp_err
);

  localparam int SW = $clog2(N);
  localparam int IW = $clog2(NREQ);

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   owner_q;
  shift_op_t       op_q;
  logic [N-1:0]    data_q;
  logic [SW-1:0]   shamt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [N-1:0]    rsp_data_q;
  logic            rsp_err_q;

  logic [IW-1:0]   grant_d;
  logic            grant_found;
  logic            accept;
  logic [N-1:0]    core_result;
  logic            core_err;

  // Search starts one past the last accepted requester.
  always_comb begin
    grant_d     = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[(int'(last_q) + k) % NREQ]) begin
        grant_d     = IW'((int'(last_q) + k) % NREQ);
        grant_found = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept && rst) req_ready[grant_d] = 1'b1;
  end

  shift_core #(.N(N), .SW(SW)) u_core (
    .op     (op_q),
    .data   (data_q),
    .shamt  (shamt_q),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(NREQ - 1);
      owner_q     <= '0;
      op_q        <= SLL;
      data_q      <= '0;
      shamt_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant_d;
            last_q  <= grant_d;
            op_q    <= shift_op_t'(req_op[grant_d*2 +: 2]);
            data_q  <= req_data[grant_d*N +: N];
            shamt_q <= req_shamt[grant_d*SW +: SW];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= core_result;
          rsp_err_q   <= core_err;
          rsp_valid_q <= NREQ'(1) << owner_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: accepted requests push a model result,
// consumed responses pop and compare. Honours SHIFT_ARBITER_ROTATE_EN for ROL expectations.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_data;
  logic [9:0]  req_shamt;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rsp_seen = 1'b0;

  always #5 clk = ~clk;

  shift_arbiter #(.N(32), .NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                                output logic [31:0] r, output logic er);
    logic [63:0] dd;
    r  = '0;
    er = 1'b0;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = 32'($signed(d) >>> s);
      default: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        dd = {d, d} << s;
        r  = dd[63:32];
`else
        dd = '0;
        er = 1'b1;
`endif
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      rsp_seen = 1'b0;
    end else begin
      cyc++;
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb[0];
          if (!rsp_seen) begin
            chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
            rsp_seen = 1'b1;
          end
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.owner));
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            void'(sb.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t n;
          n.owner   = i;
          n.acc_cyc = cyc;
          model(req_op[i*2 +: 2], req_data[i*32 +: 32], req_shamt[i*5 +: 5], n.data, n.err);
          sb.push_back(n);
          grant_log.push_back(i);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    req_op[r*2 +: 2]     = op;
    req_data[r*32 +: 32] = d;
    req_shamt[r*5 +: 5]  = s;
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input bit drain);
    bit got;
    got = 1'b0;
    set_req(r, op, d, s);
    req_valid[r] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    if (drain) wait_drain();
  endtask

  typedef struct {
    int          r;
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] bp_exp;
    logic        bp_err;
    bit          got;

    rst       = 1'b0;
    req_valid = 2'b01;
    req_op    = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 2'b11;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed single requests, including shamt=0 and sign-fill boundaries.
    vecs.push_back('{0, 2'b00, 32'h0000_0001, 5'd31});
    vecs.push_back('{0, 2'b10, 32'h8000_0000, 5'd4});
    vecs.push_back('{1, 2'b01, 32'h8000_0000, 5'd4});
    vecs.push_back('{1, 2'b11, 32'h8000_0001, 5'd1});
    vecs.push_back('{0, 2'b10, 32'h7000_0000, 5'd3});
    vecs.push_back('{1, 2'b00, 32'hDEAD_BEEF, 5'd0});
    vecs.push_back('{0, 2'b10, 32'h8123_4567, 5'd0});
    vecs.push_back('{0, 2'b11, 32'h1234_5678, 5'd0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31))});
    foreach (vecs[i]) issue(vecs[i].r, vecs[i].op, vecs[i].d, vecs[i].s, 1'b1);

    // Fairness after a fresh reset: both held valid for four operations.
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    grant_log.delete();
    set_req(0, 2'b00, 32'h0000_00F0, 5'd4);
    set_req(1, 2'b01, 32'hF000_0000, 5'd8);
    @(posedge clk);
    #1 req_valid = 2'b11;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= 4) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 2'b00;
    if (!got) chk("fair_timeout", 32'(grant_log.size()), 32'd4);
    wait_drain();
    for (int i = 0; i < 4; i++)
      chk("fair_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));

    // Backpressure on owner 0 while requester 1 waits and asserts its own rsp_ready.
    rsp_ready = 2'b10;
    model(2'b10, 32'hC000_0010, 5'd2, bp_exp, bp_err);
    issue(0, 2'b10, 32'hC000_0010, 5'd2, 1'b0);
    req_valid[1] = 1'b1;
    set_req(1, 2'b00, 32'h0000_0003, 5'd1);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid[0]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("bp_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, bp_exp);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_drain();

    // Reset in EXEC: last grant was 1, operation discarded, req0 wins next.
    issue(1, 2'b00, 32'h0000_0001, 5'd5, 1'b0);
    req_valid[1] = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    sb.delete();
    req_valid = 2'b00;
    @(negedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set_req(0, 2'b01, 32'h0000_0100, 5'd8);
    set_req(1, 2'b01, 32'h0000_0200, 5'd8);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
